bin2bcd_seq: RTL and testbench

Sequential binary-to-BCD converter (shift-and-add-3 / double dabble) sitting directly downstream of the Fibonacci circuit.
- Consumes the 20-bit result f on its done_tick and produces packed decimal digits for the seven-segment/display stage.
- Uses the same start/ready/done_tick handshake as the Fibonacci circuit, so the two chain directly (fib done_tick -> bin2bcd_seq start).

---
 rtl/bin2bcd_pkg.sv | 15 +
 rtl/bin2bcd_seq_bcd_adj3.sv | 11 +
 rtl/bin2bcd_seq.sv | 119 +++++++++++
 tb/tb_bin2bcd_seq.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/bin2bcd_pkg.sv
// Shared types and defaults for the sequential binary-to-BCD converter.
// Optional blank-digit output is enabled with macro BIN2BCD_BLANK_EN.
package bin2bcd_pkg;

   localparam int W_DEF      = 20;
   localparam int DIGITS_DEF = 7;
   localparam int BCD_W      = 4;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      OP   = 2'b01,
      DONE = 2'b10
   } state_t;

endpackage

// File: rtl/bin2bcd_seq_bcd_adj3.sv
// Double-dabble digit correction: digits of 5 or more get +3 ahead of the shift.
module bcd_adj3
   import bin2bcd_pkg::*;
(
   input  logic [BCD_W-1:0] din,
   output logic [BCD_W-1:0] dout
);

   assign dout = (din > 4'd4) ? din + 4'd3 : din;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 converter using the start/ready/done_tick handshake.
// Define BIN2BCD_BLANK_EN to add the leading-zero blank mask output.
module bin2bcd_seq
   import bin2bcd_pkg::*;
#(
   parameter int W      = W_DEF,
   parameter int DIGITS = DIGITS_DEF
)(
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      start,
   input  logic [W-1:0]              bin,
   output logic                      ready,
   output logic                      done_tick,
   output logic [BCD_W*DIGITS-1:0]   bcd
`ifdef BIN2BCD_BLANK_EN
   ,
   output logic [DIGITS-1:0]         blank
`endif
);

   localparam int NW = $clog2(W+1);
   localparam int BW = BCD_W*DIGITS;

   state_t          state, state_nxt;
   logic [W-1:0]    bin_r;
   logic [BW-1:0]   bcd_r, bcd_adj, bcd_sh, bcd_q;
   logic [NW-1:0]   n;
   logic            load, shift;

   genvar g;
   generate
      for (g = 0; g < DIGITS; g++) begin : g_adj
         bcd_adj3 u_adj (
            .din  (bcd_r  [g*BCD_W +: BCD_W]),
            .dout (bcd_adj[g*BCD_W +: BCD_W])
         );
      end
   endgenerate

   assign bcd_sh = {bcd_adj[BW-2:0], bin_r[W-1]};

   always_comb begin
      state_nxt = state;
      ready     = 1'b0;
      done_tick = 1'b0;
      load      = 1'b0;
      shift     = 1'b0;
      case (state)
         IDLE: begin
            ready = 1'b1;
            if (start) begin
               load      = 1'b1;
               state_nxt = OP;
            end
         end
         OP: begin
            shift = 1'b1;
            if (n == NW'(1)) state_nxt = DONE;
         end
         DONE: begin
            done_tick = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // bcd_q is the visible result; it only moves on shifts so the previous
   // answer survives the accept edge until the first shift of the next run.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         bin_r <= '0;
         bcd_r <= '0;
         bcd_q <= '0;
         n     <= '0;
      end else begin
         state <= state_nxt;
         if (load) begin
            bin_r <= bin;
            bcd_r <= '0;
            n     <= NW'(W);
         end else if (shift) begin
            bin_r <= bin_r << 1;
            bcd_r <= bcd_sh;
            bcd_q <= bcd_sh;
            n     <= n - NW'(1);
         end
      end
   end

   assign bcd = bcd_q;

`ifdef BIN2BCD_BLANK_EN
   logic [DIGITS-1:0] blank_nxt, blank_q;
   logic              zero_above;

   always_comb begin
      blank_nxt  = '0;
      zero_above = 1'b1;
      for (int k = DIGITS-1; k >= 0; k--) begin
         zero_above   = zero_above & (bcd_sh[k*BCD_W +: BCD_W] == '0);
         blank_nxt[k] = zero_above;
      end
      blank_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         blank_q <= {{(DIGITS-1){1'b1}}, 1'b0};
      else if (shift && n == NW'(1))
         blank_q <= blank_nxt;
   end

   assign blank = blank_q;
`endif

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq: latency, results, handshake, held start, abort.
module tb_bin2bcd_seq;

   localparam int W      = 20;
   localparam int DIGITS = 7;

   logic                  clk = 1'b0;
   logic                  reset_n, start, ready, done_tick;
   logic [W-1:0]          bin;
   logic [4*DIGITS-1:0]   bcd;
`ifdef BIN2BCD_BLANK_EN
   logic [DIGITS-1:0]     blank;
`endif

   int n_chk  = 0;
   int n_fail = 0;
   int n_done = 0;
   int cyc    = 0;

   always #5 clk = ~clk;

   bin2bcd_seq #(.W(W), .DIGITS(DIGITS)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .start     (start),
      .bin       (bin),
      .ready     (ready),
      .done_tick (done_tick),
      .bcd       (bcd)
`ifdef BIN2BCD_BLANK_EN
      ,
      .blank     (blank)
`endif
   );

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (done_tick) n_done <= n_done + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Cycle k after the accept edge is the period following edge E(k-1).
   task automatic convert(input logic [W-1:0] v, output int lat, output int rdy_hi);
      @(negedge clk);
      bin   = v;
      start = 1'b1;
      @(posedge clk); #1;
      start  = 1'b0;
      bin    = ~v;
      lat    = 1;
      rdy_hi = 0;
      while (!done_tick && lat < 60) begin
         if (ready) rdy_hi++;
         @(posedge clk); #1;
         lat++;
      end
      if (!done_tick) lat = -1;
   endtask

   task automatic wait_done(output int ok);
      ok = 0;
      for (int i = 0; i < 60 && !ok; i++) begin
         @(posedge clk); #1;
         if (done_tick) ok = 1;
      end
   endtask

   logic [W-1:0]  vin  [4] = '{20'd34, 20'd832040, 20'd1048575, 20'd0};
   logic [31:0]   vexp [4] = '{32'h0000034, 32'h0832040, 32'h1048575, 32'h0000000};

   initial begin
      int lat, rdy, ok, c1, c2, d0;
      reset_n = 1'b0;
      start   = 1'b0;
      bin     = '0;
      #12;
      check("rst_ready", 32'(ready), 32'd1);
      check("rst_done",  32'(done_tick), 32'd0);
      check("rst_bcd",   32'(bcd), 32'd0);
`ifdef BIN2BCD_BLANK_EN
      check("rst_blank", 32'(blank), 32'h7E);
`endif
      reset_n = 1'b1;

      for (int i = 0; i < 4; i++) begin
         d0 = n_done;
         convert(vin[i], lat, rdy);
         check($sformatf("lat_%0d", i),   32'(lat), 32'd21);
         check($sformatf("busy_%0d", i),  32'(rdy), 32'd0);
         check($sformatf("bcd_%0d", i),   32'(bcd), vexp[i]);
         check($sformatf("rdydn_%0d", i), 32'(ready), 32'd0);
`ifdef BIN2BCD_BLANK_EN
         if (i == 0) check("blank_34", 32'(blank), 32'h7C);
         if (i == 3) check("blank_0",  32'(blank), 32'h7E);
`endif
         @(posedge clk); #1;
         check($sformatf("idle_%0d", i), 32'({ready, done_tick}), 32'b10);
         check($sformatf("ndone_%0d", i), 32'(n_done - d0), 32'd1);
      end

      // start pulsed during OP is ignored
      d0 = n_done;
      @(negedge clk); bin = 20'd832040; start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (5) @(negedge clk);
      bin = 20'd999; start = 1'b1;
      @(negedge clk); start = 1'b0;
      wait_done(ok);
      check("ign_ok",  32'(ok), 32'd1);
      check("ign_bcd", 32'(bcd), 32'h0832040);
      repeat (30) @(posedge clk);
      #1;
      check("ign_ndone", 32'(n_done - d0), 32'd1);

      // start held high: back-to-back conversions
      @(negedge clk); bin = 20'd34; start = 1'b1;
      wait_done(ok);
      c1 = cyc;
      check("held_ok1", 32'(ok), 32'd1);
      check("held_bcd1", 32'(bcd), 32'h0000034);
      bin = 20'd3;
      repeat (2) @(posedge clk);
      #1;
      check("held_keep", 32'(bcd), 32'h0000034);
      wait_done(ok);
      c2 = cyc;
      start = 1'b0;
      check("held_ok2", 32'(ok), 32'd1);
      check("held_gap", 32'(c2 - c1), 32'd22);
      check("held_bcd2", 32'(bcd), 32'h0000003);
      repeat (3) @(posedge clk);

      // asynchronous reset in the middle of a conversion
      @(negedge clk); bin = 20'd1048575; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      repeat (9) @(posedge clk);
      #3;
      d0 = n_done;
      reset_n = 1'b0;
      #1;
      check("abort_ready", 32'(ready), 32'd1);
      check("abort_bcd",   32'(bcd), 32'd0);
      #1;
      reset_n = 1'b1;
      repeat (30) @(posedge clk);
      #1;
      check("abort_ndone", 32'(n_done - d0), 32'd0);
      convert(20'd55, lat, rdy);
      check("post_lat", 32'(lat), 32'd21);
      check("post_bcd", 32'(bcd), 32'h0000055);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
